// File: rtl/digit_entry_ctrl_if.sv
// -----------------------------------------------------------------------------
// digit_entry_ctrl_if
// Purpose : Bundles the key/digit inputs and the operand/handshake outputs of
//           digit_entry_ctrl into one interface so the keypad side, the
//           consumer side and the controller share a single connection.
// Parameter:
//   NDIG        maximum number of BCD digits per operand (1..8)
// Signals:
//   keystrobe   one-cycle pulse per key press, aligned with keycode
//   keycode     raw key code; 10 enter, 11 clear, 12 backspace, 13-15 ignored
//   isdig       one-cycle pulse, digitCode holds a decoded digit
//   digitCode   decoded digit 0-9
//   value_ack   consumer accepts the held operand
//   entry_bcd   operand being built/held, nibble 0 = least-significant digit
//   digit_count number of digits currently entered
//   value_valid completed operand held on entry_bcd
//   overflow    one-cycle pulse, digit rejected because operand full
//   busy        digit_count != 0 or value_valid
// Modports:
//   master      keypad/consumer side (drives keys and ack)
//   slave       controller side (drives operand and status)
// -----------------------------------------------------------------------------
interface digit_entry_ctrl_if #(
   parameter int NDIG = 4
);
   localparam int CW = $clog2(NDIG + 1);

   logic                keystrobe;
   logic [3:0]          keycode;
   logic                isdig;
   logic [3:0]          digitCode;
   logic                value_ack;
   logic [4*NDIG-1:0]   entry_bcd;
   logic [CW-1:0]       digit_count;
   logic                value_valid;
   logic                overflow;
   logic                busy;

   modport master (
      output keystrobe, keycode, isdig, digitCode, value_ack,
      input  entry_bcd, digit_count, value_valid, overflow, busy
   );

   modport slave (
      input  keystrobe, keycode, isdig, digitCode, value_ack,
      output entry_bcd, digit_count, value_valid, overflow, busy
   );
endinterface

// File: rtl/digit_entry_ctrl.sv
// -----------------------------------------------------------------------------
// digit_entry_ctrl
// Purpose : Assembles decoded digits MSD-first into a multi-digit BCD operand,
//           handles the enter / clear / backspace function keys, holds the
//           completed operand under a valid/ack handshake and pulses overflow
//           when a digit arrives while the operand is already full.
// Parameter:
//   NDIG   maximum number of BCD digits per operand (1..8)
// Ports:
//   clk    system clock, rising edge
//   nrst   asynchronous active-low reset
//   bus    digit_entry_ctrl_if.slave (keys, digits, ack in; operand/status out)
// Optional feature macro:
//   BACKSPACE_EN  when defined, keycode 12 removes the last entered digit;
//                 when undefined keycode 12 is ignored like 13-15.
// -----------------------------------------------------------------------------
module digit_entry_ctrl #(
   parameter int NDIG = 4
) (
   input  logic                clk,
   input  logic                nrst,
   digit_entry_ctrl_if.slave   bus
);

   localparam int CW = $clog2(NDIG + 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(NDIG);

   typedef enum logic {
      ENTRY = 1'b0,
      HOLD  = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic [4*NDIG-1:0] entry_q, entry_d;
   logic [CW-1:0]     count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              clearEv;
   logic              enterEv;
   logic              digitEv;
   logic [4*NDIG-1:0] shiftedIn;
`ifdef BACKSPACE_EN
   logic              backEv;
`endif

   // Key decoding. Function keys only count with keystrobe; digits come
   // solely from the decoder, and a decoder code above 9 is not a digit.
   always_comb begin
      clearEv = bus.keystrobe && (bus.keycode == 4'd11);
      enterEv = bus.keystrobe && (bus.keycode == 4'd10);
      digitEv = bus.isdig && (bus.digitCode <= 4'd9);
   end

`ifdef BACKSPACE_EN
   // Backspace decode exists only in the backspace-enabled build.
   always_comb begin
      backEv = bus.keystrobe && (bus.keycode == 4'd12);
   end
`endif

   // New digit enters at nibble 0 and older digits move up one nibble; with a
   // single-digit operand there is nothing to move.
   generate
      if (NDIG == 1) begin : g_shift_one
         assign shiftedIn = bus.digitCode;
      end else begin : g_shift_many
         assign shiftedIn = {entry_q[4*NDIG-5:0], bus.digitCode};
      end
   endgenerate

   // State and operand registers; reset clears everything immediately.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= ENTRY;
         entry_q    <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         entry_q    <= entry_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Next-state logic. The if/else chain encodes the event priority
   // clear > enter > backspace > digit, so at most one event acts per cycle.
   // In HOLD only ack and clear do anything; everything else is dropped
   // silently, including digits (no overflow pulse).
   always_comb begin
      state_d    = state_q;
      entry_d    = entry_q;
      count_d    = count_q;
      overflow_d = 1'b0;
      case (state_q)
         ENTRY: begin
            if (clearEv) begin
               entry_d = '0;
               count_d = '0;
            end else if (enterEv) begin
               if (count_q != '0) begin
                  state_d = HOLD;
               end
`ifdef BACKSPACE_EN
            end else if (backEv) begin
               if (count_q != '0) begin
                  entry_d = entry_q >> 4;
                  count_d = count_q - CW'(1);
               end
`endif
            end else if (digitEv) begin
               if (count_q < FULL_COUNT) begin
                  entry_d = shiftedIn;
                  count_d = count_q + CW'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (bus.value_ack || clearEv) begin
               state_d = ENTRY;
               entry_d = '0;
               count_d = '0;
            end
         end
         default: begin
            state_d = ENTRY;
            entry_d = '0;
            count_d = '0;
         end
      endcase
   end

   // Outputs are taken straight from registers, so each event shows up the
   // cycle after the edge that sampled it.
   always_comb begin
      bus.entry_bcd   = entry_q;
      bus.digit_count = count_q;
      bus.value_valid = (state_q == HOLD);
      bus.overflow    = overflow_q;
      bus.busy        = (count_q != '0) || (state_q == HOLD);
   end

endmodule
